// File: rtl/uart_mmio_pkg.sv
// Register map, status/control bit positions and FSM encodings for the MMIO UART.
package uart_mmio_pkg;

    localparam logic [1:0] REG_DIV    = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_RX_AVAIL  = 0;
    localparam int STAT_TX_BUSY   = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_CLR    = 1;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_mmio_if.sv
// picorv32-style native bus slice seen by the UART: address-qualified valid, one-cycle ready pulse.
interface uart_mmio_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead head; push and pop take effect at the clock edge.
// Push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/uart_mmio.sv
// MMIO UART: 8N1 TX/RX with RX FIFO and level IRQ; bus ready is registered, one cycle after valid.
// A DATA write while TX is busy holds ready low until the transmitter returns to idle.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = 139,
    parameter int unsigned RX_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       resetn,
    uart_mmio_if.slave bus,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       irq
);
    logic [31:0] div, eff_div, half_div, status;
    logic        irq_en, overrun, frame_err;
    logic [1:0]  tx_state, rx_state, reg_sel;
    logic [31:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shift, rx_shift, fifo_head;
    logic        rx_s1, rx_s2, rx_s3;
    logic        wr, data_wr, tx_busy, accept, ctrl_clr;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty, rx_ferr;
    logic        unused_addr;

    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
    assign eff_div     = (div < 32'd4) ? 32'd4 : div;
    assign half_div    = eff_div >> 1;
    assign reg_sel     = bus.addr[3:2];
    assign wr          = |bus.wstrb;
    assign tx_busy     = (tx_state != TX_IDLE);
    assign data_wr     = wr && (reg_sel == REG_DATA);
    // Gating on !ready stops a still-high valid from completing a second time.
    assign accept      = bus.valid && !bus.ready && !(data_wr && tx_busy);
    assign fifo_pop    = accept && !wr && (reg_sel == REG_DATA) && !fifo_empty;
    assign ctrl_clr    = accept && (reg_sel == REG_CTRL) && bus.wstrb[0] && bus.wdata[CTRL_CLR];
    assign fifo_push   = (rx_state == RX_STOP) && (rx_cnt == 32'd0) && rx_s2;
    assign rx_ferr     = (rx_state == RX_STOP) && (rx_cnt == 32'd0) && !rx_s2;

    always_comb begin
        status                 = '0;
        status[STAT_RX_AVAIL]  = !fifo_empty;
        status[STAT_TX_BUSY]   = tx_busy;
        status[STAT_OVERRUN]   = overrun;
        status[STAT_FRAME_ERR] = frame_err;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            div       <= 32'(DEFAULT_DIV);
            irq_en    <= 1'b0;
        end else begin
            bus.ready <= accept;
            if (accept) begin
                bus.rdata <= '0;
                case (reg_sel)
                    REG_DIV: begin
                        if (!wr) bus.rdata <= div;
                        for (int i = 0; i < 4; i++)
                            if (bus.wstrb[i]) div[8*i +: 8] <= bus.wdata[8*i +: 8];
                    end
                    REG_DATA: begin
                        if (!wr) bus.rdata <= fifo_empty ? 32'hFFFF_FFFF : {24'h0, fifo_head};
                    end
                    REG_STATUS: begin
                        if (!wr) bus.rdata <= status;
                    end
                    default: begin
                        if (!wr) bus.rdata <= {31'h0, irq_en};
                        else if (bus.wstrb[0]) irq_en <= bus.wdata[CTRL_IRQ_EN];
                    end
                endcase
            end
        end
    end

    // A fresh error in the same cycle as a clear is kept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_clr) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (fifo_push && fifo_full && !fifo_pop) overrun <= 1'b1;
            if (rx_ferr) frame_err <= 1'b1;
            irq <= irq_en && !fifo_empty;
        end
    end

    // Each bit reloads from eff_div, so a DIV write lands on the next bit boundary.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (accept && data_wr) begin
                        tx_state <= TX_START;
                        tx_shift <= bus.wdata[7:0];
                        tx_cnt   <= eff_div - 32'd1;
                        uart_tx  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == 32'd0) begin
                        tx_state <= TX_DATA;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= '0;
                        tx_cnt   <= eff_div - 32'd1;
                    end else tx_cnt <= tx_cnt - 32'd1;
                end
                TX_DATA: begin
                    if (tx_cnt == 32'd0) begin
                        tx_cnt <= eff_div - 32'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else tx_cnt <= tx_cnt - 32'd1;
                end
                default: begin
                    if (tx_cnt == 32'd0) tx_state <= TX_IDLE;
                    else tx_cnt <= tx_cnt - 32'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= half_div - 32'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 32'd0) begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_cnt   <= eff_div - 32'd1;
                        rx_bit   <= '0;
                    end else rx_cnt <= rx_cnt - 32'd1;
                end
                RX_DATA: begin
                    if (rx_cnt == 32'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= eff_div - 32'd1;
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else rx_cnt <= rx_cnt - 32'd1;
                end
                default: begin
                    if (rx_cnt == 32'd0) rx_state <= RX_IDLE;
                    else rx_cnt <= rx_cnt - 32'd1;
                end
            endcase
        end
    end

    uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (fifo_push),
        .push_dat (rx_shift),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with DEFAULT_DIV=16: register table plus TX/RX frame sequences.
module tb_uart_mmio;
    logic clk = 1'b0;
    logic resetn;
    logic uart_rx;
    logic uart_tx;
    logic irq;
    bit   rx_abort = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    localparam logic [31:0] BASE = 32'h0200_0000;

    uart_mmio_if b();

    uart_mmio #(.DEFAULT_DIV(16), .RX_DEPTH(4)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (b),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns right after the edge on which ready was seen; lat counts edges from valid.
    task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
        int w;
        w = 0;
        while (b.ready && w < 10) begin tick(); w++; end
        b.valid = 1'b1;
        b.addr  = a;
        b.wdata = d;
        b.wstrb = s;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!b.ready && lat < 2000);
        rd      = b.rdata;
        b.valid = 1'b0;
        b.wstrb = 4'h0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus_op(a, 32'h0, 4'h0, rd, lat);
        check(name, rd, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bus_op(a, d, 4'hF, rd, lat);
    endtask

    // Checks every cycle of a frame; first_len covers the start bit, rest_len the others.
    task automatic tx_frame(input logic [7:0] d, input int first_len, input int rest_len, input string tag);
        logic [9:0] fr;
        int w;
        int bad;
        int len;
        fr = {1'b1, d, 1'b0};
        w = 0;
        while (uart_tx !== 1'b0 && w < 400) begin tick(); w++; end
        check({tag, "_start_seen"}, {31'h0, uart_tx}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            len = (i == 0) ? first_len : rest_len;
            for (int c = 0; c < len; c++) begin
                if (uart_tx !== fr[i]) bad++;
                tick();
            end
            check($sformatf("%s_bit%0d_wrong_cycles", tag, i), bad, 0);
        end
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop, input int bl);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            for (int c = 0; c < bl; c++) begin
                tick();
                if (rx_abort) begin
                    uart_rx = 1'b1;
                    return;
                end
            end
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int t0;

        vecs[0]  = '{BASE + 32'h0, 32'h0,         4'h0, 32'h0000_0010};
        vecs[1]  = '{BASE + 32'h4, 32'h0,         4'h0, 32'hFFFF_FFFF};
        vecs[2]  = '{BASE + 32'h8, 32'h0,         4'h0, 32'h0000_0000};
        vecs[3]  = '{BASE + 32'hC, 32'h0,         4'h0, 32'h0000_0000};
        vecs[4]  = '{BASE + 32'h0, 32'h1234_5678, 4'h1, 32'h0};
        vecs[5]  = '{BASE + 32'h0, 32'h0,         4'h0, 32'h0000_0078};
        vecs[6]  = '{BASE + 32'h0, 32'hABCD_0000, 4'hC, 32'h0};
        vecs[7]  = '{BASE + 32'h0, 32'h0,         4'h0, 32'hABCD_0078};
        vecs[8]  = '{BASE + 32'h0, 32'h0000_0010, 4'hF, 32'h0};
        vecs[9]  = '{BASE + 32'h0, 32'h0,         4'h0, 32'h0000_0010};
        vecs[10] = '{BASE + 32'hC, 32'h0000_0003, 4'h1, 32'h0};
        vecs[11] = '{BASE + 32'hC, 32'h0,         4'h0, 32'h0000_0001};
        vecs[12] = '{BASE + 32'h8, 32'h0000_000F, 4'hF, 32'h0};
        vecs[13] = '{BASE + 32'h8, 32'h0,         4'h0, 32'h0000_0000};
        vecs[14] = '{BASE + 32'hC, 32'h0,         4'h1, 32'h0};
        vecs[15] = '{BASE + 32'hC, 32'h0,         4'h0, 32'h0000_0000};

        resetn  = 1'b0;
        uart_rx = 1'b1;
        b.valid = 1'b0;
        b.wstrb = 4'h0;
        b.addr  = 32'h0;
        b.wdata = 32'h0;
        repeat (5) tick();
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_ready", {31'h0, b.ready}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rdata", b.rdata, 32'h0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            bus_op(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
            check($sformatf("vec%0d_latency", i), lat, 1);
            if (vecs[i].wstrb == 4'h0) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            tick();
        end

        // TX 0x55 with a STATUS read in the middle of the frame.
        bus_op(BASE + 32'h4, 32'h0000_0055, 4'h1, rd, lat);
        check("tx55_latency", lat, 1);
        fork
            tx_frame(8'h55, 16, 16, "tx55");
            begin
                repeat (20) tick();
                rd_chk("tx55_status_busy", BASE + 32'h8, 32'h0000_0002);
            end
        join
        rd_chk("tx55_status_idle", BASE + 32'h8, 32'h0000_0000);

        // Back-to-back DATA writes: second ready waits for the first stop bit.
        bus_op(BASE + 32'h4, 32'h0000_00A3, 4'hF, rd, lat);
        t0 = cyc;
        fork
            begin
                bus_op(BASE + 32'h4, 32'h0000_000F, 4'hF, rd, lat);
                check("bp_second_ready_cycle", cyc - t0, 161);
            end
            begin
                tx_frame(8'hA3, 16, 16, "bpA3");
                tx_frame(8'h0F, 16, 16, "bp0F");
            end
        join

        // Divisor below 4 is clamped to 4.
        wr(BASE + 32'h0, 32'h0000_0002);
        bus_op(BASE + 32'h4, 32'h0000_005A, 4'h1, rd, lat);
        tx_frame(8'h5A, 4, 4, "txmin");

        // DIV changed during the start bit applies from the next bit.
        wr(BASE + 32'h0, 32'h0000_0010);
        bus_op(BASE + 32'h4, 32'h0000_0096, 4'h1, rd, lat);
        fork
            tx_frame(8'h96, 16, 32, "txdiv");
            wr(BASE + 32'h0, 32'h0000_0020);
        join
        wr(BASE + 32'h0, 32'h0000_0010);

        // RX with interrupt enabled.
        wr(BASE + 32'hC, 32'h0000_0001);
        rx_send(8'hC4, 1'b1, 16);
        check("rx_irq_high", {31'h0, irq}, 32'h1);
        rd_chk("rx_status", BASE + 32'h8, 32'h0000_0001);
        rd_chk("rx_data", BASE + 32'h4, 32'h0000_00C4);
        tick();
        tick();
        check("rx_irq_low", {31'h0, irq}, 32'h0);
        rd_chk("rx_data_empty", BASE + 32'h4, 32'hFFFF_FFFF);

        // Five bytes into a four-entry FIFO with interrupt disabled.
        wr(BASE + 32'hC, 32'h0000_0002);
        rx_send(8'h11, 1'b1, 16);
        rx_send(8'h22, 1'b1, 16);
        rx_send(8'h33, 1'b1, 16);
        rx_send(8'h44, 1'b1, 16);
        rx_send(8'h55, 1'b1, 16);
        check("ovr_irq_disabled", {31'h0, irq}, 32'h0);
        rd_chk("ovr_status", BASE + 32'h8, 32'h0000_0005);
        rd_chk("ovr_data0", BASE + 32'h4, 32'h0000_0011);
        rd_chk("ovr_data1", BASE + 32'h4, 32'h0000_0022);
        rd_chk("ovr_data2", BASE + 32'h4, 32'h0000_0033);
        rd_chk("ovr_data3", BASE + 32'h4, 32'h0000_0044);
        rd_chk("ovr_data_empty", BASE + 32'h4, 32'hFFFF_FFFF);
        rx_send(8'h77, 1'b0, 16);
        rd_chk("ferr_status", BASE + 32'h8, 32'h0000_000C);
        rd_chk("ferr_data_dropped", BASE + 32'h4, 32'hFFFF_FFFF);
        wr(BASE + 32'hC, 32'h0000_0002);
        rd_chk("clr_status", BASE + 32'h8, 32'h0000_0000);

        // Reset in the middle of a TX frame and an RX frame.
        wr(BASE + 32'h0, 32'h0000_0020);
        bus_op(BASE + 32'h4, 32'h0000_0000, 4'h1, rd, lat);
        fork
            rx_send(8'hA5, 1'b1, 32);
            begin
                repeat (100) tick();
                check("mid_tx_low_before_reset", {31'h0, uart_tx}, 32'h0);
                resetn = 1'b0;
                tick();
                check("mid_tx_high_after_reset", {31'h0, uart_tx}, 32'h1);
                check("mid_ready_after_reset", {31'h0, b.ready}, 32'h0);
                tick();
                resetn   = 1'b1;
                rx_abort = 1'b1;
            end
        join
        repeat (200) tick();
        rd_chk("mid_fifo_empty", BASE + 32'h4, 32'hFFFF_FFFF);
        rd_chk("mid_div_reset", BASE + 32'h0, 32'h0000_0010);
        rd_chk("mid_status", BASE + 32'h8, 32'h0000_0000);
        check("mid_uart_tx_idle", {31'h0, uart_tx}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
